// File: rtl/tune_if.sv
// Control/status bundle for tune_sequencer: start/abort and tune data in,
// sequencing status and speaker output back.
interface tune_if;
  logic        start;
  logic        abort;
  logic [47:0] notes;
  logic [1:0]  reps;
  logic        busy;
  logic [1:0]  note_idx;
  logic        pwm;
  logic        done;

  modport master (output start, abort, notes, reps, input busy, note_idx, pwm, done);
  modport slave  (input start, abort, notes, reps, output busy, note_idx, pwm, done);
endinterface

// File: rtl/tune_sequencer.sv
// Plays a snapshotted three-note tune (pitch/duration byte pairs) for reps+1 passes.
// Optional feature macro: TUNE_RESTART_EN (start while busy restarts the tune).
module tune_sequencer #(
  parameter int TICKS_PER_UNIT = 240000,
  parameter int HALF_BASE      = 6000,
  parameter int HALF_STEP      = 40,
  parameter int GAP_TICKS      = 24000
) (
  input  logic   int_osc,
  input  logic   reset_n,
  tune_if.slave  bus
);
  localparam int PW = $clog2(TICKS_PER_UNIT + 1);
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_UNIT - 1);
  localparam logic [GW-1:0] GMAX = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t        state;
  logic [47:0]   snap;
  logic [1:0]    reps_s, pass, idx;
  logic [15:0]   half, tcnt;
  logic [PW-1:0] pre;
  logic [7:0]    unit;
  logic [GW-1:0] gcnt;
  logic          busy_q, pwm_q, done_q;

  logic [7:0] cur_p, cur_d;
  logic       play_end, gap_end, adv, adv_fin;
  logic [1:0] adv_idx, adv_pass;

  always_comb begin
    cur_p = snap[47:40];
    cur_d = snap[39:32];
    case (idx)
      2'd1: begin cur_p = snap[31:24]; cur_d = snap[23:16]; end
      2'd2: begin cur_p = snap[15:8];  cur_d = snap[7:0];   end
      default: ;
    endcase
  end

  // A note ends at LOAD when d=0, at the last PLAY cycle when there is no gap,
  // or at the last GAP cycle; all share the same advance decision.
  always_comb begin
    play_end = (pre == PMAX) && (unit == cur_d - 8'd1);
    gap_end  = (gcnt == GMAX);
    adv      = ((state == LOAD) && (cur_d == 8'd0)) ||
               ((state == PLAY) && play_end && (GAP_TICKS == 0)) ||
               ((state == GAP) && gap_end);
    adv_fin  = (idx == 2'd2) && !(pass < reps_s);
    adv_idx  = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    adv_pass = ((idx == 2'd2) && (pass < reps_s)) ? pass + 2'd1 : pass;
  end

  always_ff @(posedge int_osc or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      snap   <= '0;
      reps_s <= '0;
      pass   <= '0;
      idx    <= '0;
      half   <= '0;
      tcnt   <= '0;
      pre    <= '0;
      unit   <= '0;
      gcnt   <= '0;
      busy_q <= 1'b0;
      pwm_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        state  <= IDLE;
        busy_q <= 1'b0;
        idx    <= '0;
        pwm_q  <= 1'b0;
`ifdef TUNE_RESTART_EN
      end else if (bus.start && state != IDLE) begin
        snap   <= bus.notes;
        reps_s <= bus.reps;
        idx    <= '0;
        pass   <= '0;
        pwm_q  <= 1'b0;
        state  <= LOAD;
`endif
      end else if (adv) begin
        pwm_q  <= 1'b0;
        idx    <= adv_idx;
        pass   <= adv_pass;
        state  <= adv_fin ? IDLE : LOAD;
        busy_q <= !adv_fin;
        done_q <= adv_fin;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            snap   <= bus.notes;
            reps_s <= bus.reps;
            idx    <= '0;
            pass   <= '0;
            busy_q <= 1'b1;
            state  <= LOAD;
          end
          LOAD: begin
            half  <= 16'(HALF_BASE) + 16'(cur_p) * 16'(HALF_STEP);
            pre   <= '0;
            unit  <= '0;
            tcnt  <= '0;
            gcnt  <= '0;
            pwm_q <= (cur_p != 8'd0);
            state <= PLAY;
          end
          PLAY: begin
            if (pre == PMAX) begin
              pre  <= '0;
              unit <= unit + 8'd1;
            end else begin
              pre <= pre + 1'b1;
            end
            // Rest notes keep counting but never toggle, so pwm stays 0.
            if (tcnt == half - 16'd1) begin
              tcnt <= '0;
              if (cur_p != 8'd0) pwm_q <= ~pwm_q;
            end else begin
              tcnt <= tcnt + 16'd1;
            end
            if (play_end) begin
              pwm_q <= 1'b0;
              gcnt  <= '0;
              state <= GAP;
            end
          end
          GAP: gcnt <= gcnt + 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.note_idx = idx;
  assign bus.pwm      = pwm_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_tune_sequencer.sv
// Scoreboard bench for tune_sequencer: a note-level model expands each accepted
// tune into per-cycle expected outputs; a negedge monitor pops and compares.
module tb_tune_sequencer;
  localparam int T = 10, HB = 4, HS = 1, G = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tune_if bus();

  tune_sequencer #(.TICKS_PER_UNIT(T), .HALF_BASE(HB), .HALF_STEP(HS), .GAP_TICKS(G)) dut (
    .int_osc (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic       busy;
    logic [1:0] idx;
    logic       pwm;
    logic       done;
  } obs_t;

  obs_t q[$];
  int   tests = 0, fails = 0;
  bit   mon_en = 1'b0;
  obs_t m_e, m_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs of one whole tune, from the note rules directly.
  task automatic push_tune(input logic [47:0] n, input logic [1:0] r);
    int p, d, h;
    for (int ps = 0; ps <= int'(r); ps++)
      for (int i = 0; i < 3; i++) begin
        p = int'(n[47-16*i -: 8]);
        d = int'(n[39-16*i -: 8]);
        h = HB + p * HS;
        q.push_back('{1'b1, 2'(i), 1'b0, 1'b0});
        if (d != 0) begin
          for (int c = 0; c < d * T; c++)
            q.push_back('{1'b1, 2'(i), (p != 0) && ((c / h) % 2 == 0), 1'b0});
          for (int g = 0; g < G; g++)
            q.push_back('{1'b1, 2'(i), 1'b0, 1'b0});
        end
      end
    q.push_back('{1'b0, 2'd0, 1'b0, 1'b1});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      m_e = (q.size() != 0) ? q.pop_front() : obs_t'(0);
      m_a = '{bus.busy, bus.note_idx, bus.pwm, bus.done};
      chk("cycle{busy,idx,pwm,done}", 32'(m_a), 32'(m_e));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller sits at posedge+1; start is sampled at the following edge.
  task automatic do_start(input logic [47:0] n, input logic [1:0] r);
    bus.notes = n;
    bus.reps  = r;
    bus.start = 1'b1;
    @(posedge clk);
    if (q.size() == 0) push_tune(n, r);
`ifdef TUNE_RESTART_EN
    else begin
      q.delete();
      push_tune(n, r);
    end
`endif
    #1 bus.start = 1'b0;
  endtask

  task automatic do_abort(input logic with_start);
    bus.abort = 1'b1;
    bus.start = with_start;
    @(posedge clk);
    q.delete();
    #1;
    bus.abort = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp, input int maxc);
    int n;
    n = 0;
    while (n < maxc) begin
      step();
      n++;
      if (bus.done === 1'b1) break;
    end
    if (bus.done !== 1'b1) chk({name, " timeout"}, 32'(n), 32'(exp + 1000));
    else chk({name, " done cycle"}, 32'(n), 32'(exp));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      if (bus.busy) bus.notes = {$urandom, $urandom};
      step();
      n++;
    end
    if (q.size() != 0) chk({name, " drain timeout"}, 32'(q.size()), 32'd0);
    step();
  endtask

  function automatic logic [47:0] rand_notes();
    logic [47:0] v;
    for (int i = 0; i < 6; i++) v[8*i +: 8] = 8'($urandom_range(0, 3));
    return v;
  endfunction

  logic [47:0] tune_a, tune_b, tune_c, tune_z;
  int k;

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.notes = '0;
    bus.reps  = '0;
    tune_a = {8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2};
    tune_b = {8'd2, 8'd2, 8'd3, 8'd2, 8'd0, 8'd2};
    tune_c = {8'd1, 8'd2, 8'd0, 8'd2, 8'd1, 8'd0};
    tune_z = {8'd1, 8'd0, 8'd2, 8'd0, 8'd3, 8'd0};

    #2;
    chk("reset outputs", 32'({bus.busy, bus.note_idx, bus.pwm, bus.done}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    step();

    // basic tune, single pass
    do_start(tune_a, 2'd0);
    wait_done("t1", 69, 200);
    step();
    chk("t1 done one cycle", 32'(bus.done), 32'd0);

    // back-to-back start, three passes
    do_start(tune_a, 2'd2);
    wait_done("t2", 207, 400);
    step();

    // rest note and zero-duration note
    do_start(tune_c, 2'd0);
    wait_done("t3", 47, 200);
    step();

    // all-zero durations, two passes
    do_start(tune_z, 2'd1);
    wait_done("tz", 6, 50);
    step();

    // abort with simultaneous start
    do_start(tune_a, 2'd0);
    repeat (29) step();
    do_abort(1'b1);
    chk("abort idle", 32'({bus.busy, bus.note_idx, bus.pwm, bus.done}), 32'd0);
    repeat (5) step();

    // asynchronous reset in PLAY
    do_start(tune_a, 2'd0);
    repeat (8) step();
    #1 rst_n = 1'b0;
    #1;
    chk("async reset outputs", 32'({bus.busy, bus.note_idx, bus.pwm, bus.done}), 32'd0);
    rst_n = 1'b1;
    q.delete();
    step();
    do_start(tune_a, 2'd0);
    wait_done("t5 after reset", 69, 200);
    step();

    // second start during note 0
    do_start(tune_a, 2'd0);
    repeat (15) step();
    do_start(tune_b, 2'd0);
`ifdef TUNE_RESTART_EN
    wait_done("t6 restart", 69, 200);
`else
    wait_done("t6 ignored", 53, 200);
`endif
    step();

    // randomized tunes, with input noise while busy and occasional aborts
    for (int t = 0; t < 10; t++) begin
      do_start(rand_notes(), 2'($urandom_range(0, 3)));
      if (t % 4 == 3) begin
        k = $urandom_range(1, 40);
        repeat (k) step();
        do_abort(1'($urandom_range(0, 1)));
        repeat (3) step();
      end else begin
        drain("rand");
      end
    end

    repeat (4) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
